// File: rtl/lsu_pkg.sv
// Shared constants and lane-mask helper for the queued load/store unit.
package lsu_pkg;

  localparam logic [1:0] SIZE_1B = 2'd0;
  localparam logic [1:0] SIZE_2B = 2'd1;
  localparam logic [1:0] SIZE_4B = 2'd2;
  localparam logic [1:0] SIZE_8B = 2'd3;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  // Widest supported bus is 64 bits, so masks never exceed 8 lanes.
  localparam int unsigned MAX_NB = 8;

  // Lanes offset .. min(offset+len, nb)-1 set.
  function automatic logic [MAX_NB-1:0] be_mask(input logic [3:0] offset,
                                                input logic [3:0] len,
                                                input logic [3:0] nb);
    logic [MAX_NB-1:0] m;
    logic [4:0]        stop;
    m    = '0;
    stop = 5'(offset) + 5'(len);
    for (int i = 0; i < int'(MAX_NB); i++) begin
      if ((5'(i) >= 5'(offset)) && (5'(i) < stop) && (5'(i) < 5'(nb))) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/lsu_req_fifo.sv
// Generic synchronous FIFO holding packed request entries; head is show-ahead.
module lsu_req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     a_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Storage write; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  // Read/write pointers with wrap bit for full/empty disambiguation.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + CNT_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lsu_queued.sv
// Queued load/store unit: buffers requests, issues one or two word beats each,
// merges split reads and returns a tagged completion per request.
module lsu_queued
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned TID_W  = 2
) (
  input  logic                  clk,
  input  logic                  a_rst,
  input  logic                  rq_valid,
  output logic                  rq_ready,
  input  logic [ADDR_W-1:0]     rq_addr,
  input  logic [DATA_W-1:0]     rq_data,
  input  logic [1:0]            rq_size,
  input  logic                  rq_cmd,
  input  logic [TID_W-1:0]      rq_t_id,
  input  logic                  mem_rdy,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic                  mem_cmd,
  output logic                  mem_bus_assert,
  output logic                  rs_valid,
  output logic [DATA_W-1:0]     rs_data,
  output logic [TID_W-1:0]      rs_t_id,
  output logic                  rs_cmd
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned ENT_W = ADDR_W + DATA_W + 2 + 1 + TID_W;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SH_W  = OFF_W + 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              push, pop, final_beat;
  logic              q_full, q_empty;
  logic [CNT_W-1:0]  q_count;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] h_addr, word_addr;
  logic [DATA_W-1:0] h_data;
  logic [1:0]        h_size;
  logic              h_cmd;
  logic [TID_W-1:0]  h_tid;
  logic [3:0]        off, raw_len, len, end_b, len1;
  logic              split;
  logic [SH_W-1:0]   sh0, sh1;
  logic [NB-1:0]     len_mask;
  logic [DATA_W-1:0] res_mask, rd_lo, rd_hi, merged, merge_q;

  assign rq_ready       = ~q_full;
  assign push           = rq_valid & rq_ready;
  assign mem_bus_assert = (state_q != ST_IDLE);

  lsu_req_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
    .clk   (clk),
    .a_rst (a_rst),
    .push  (push),
    .din   ({rq_addr, rq_data, rq_size, rq_cmd, rq_t_id}),
    .pop   (pop),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign {h_addr, h_data, h_size, h_cmd, h_tid} = head;

  // Access geometry of the head entry; oversize accesses clamp to one word.
  assign off       = 4'(h_addr[OFF_W-1:0]);
  assign raw_len   = 4'd1 << h_size;
  assign len       = (raw_len > 4'(NB)) ? 4'(NB) : raw_len;
  assign end_b     = off + len;
  assign split     = (end_b > 4'(NB));
  assign len1      = end_b - 4'(NB);
  assign sh0       = SH_W'({off, 3'b000});
  assign sh1       = SH_W'({4'(NB) - off, 3'b000});
  assign word_addr = h_addr & ~ADDR_W'(NB - 1);
  assign len_mask  = NB'(be_mask(4'd0, len, 4'(NB)));

  // Read lane steering: beat 0 lanes o.. to bytes 0.., beat 1 lanes 0.. to bytes NB-o..
  assign rd_lo  = mem_rdata >> sh0;
  assign rd_hi  = mem_rdata << sh1;
  assign merged = (state_q == ST_BEAT1) ? (merge_q | rd_hi) : rd_lo;

  // Expand the per-byte length mask to bits for zero-extension.
  always_comb begin
    res_mask = '0;
    for (int b = 0; b < int'(NB); b++) res_mask[8*b +: 8] = {8{len_mask[b]}};
  end

  // Issue FSM next state, dequeue and bus drive.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    final_beat = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    mem_cmd    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!q_empty || push) state_d = ST_BEAT0;
      end
      ST_BEAT0: begin
        mem_addr  = word_addr;
        mem_be    = NB'(be_mask(off, len, 4'(NB)));
        mem_wdata = h_data << sh0;
        mem_cmd   = h_cmd;
        if (mem_rdy) begin
          if (split) state_d = ST_BEAT1;
          else       final_beat = 1'b1;
        end
      end
      ST_BEAT1: begin
        mem_addr  = word_addr + ADDR_W'(NB);
        mem_be    = NB'(be_mask(4'd0, len1, 4'(NB)));
        mem_wdata = h_data >> sh1;
        mem_cmd   = h_cmd;
        if (mem_rdy) final_beat = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (final_beat) begin
      pop     = 1'b1;
      state_d = ((q_count > CNT_W'(1)) || push) ? ST_BEAT0 : ST_IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Low half of a split read, captured when beat 0 completes.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst)                                        merge_q <= '0;
    else if ((state_q == ST_BEAT0) && mem_rdy && split) merge_q <= rd_lo;
  end

  // Completion register; single-cycle rs_valid per finished request.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      rs_valid <= 1'b0;
      rs_data  <= '0;
      rs_t_id  <= '0;
      rs_cmd   <= 1'b0;
    end else begin
      rs_valid <= final_beat;
      if (final_beat) begin
        rs_data <= (h_cmd == CMD_WR) ? '0 : (merged & res_mask);
        rs_t_id <= h_tid;
        rs_cmd  <= h_cmd;
      end
    end
  end

endmodule

// File: tb/tb_lsu_queued.sv
// Directed bench for lsu_queued at DATA_W=16, DEPTH=2.
module tb_lsu_queued;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        rq_valid, rq_ready;
  logic [15:0] rq_addr, rq_data;
  logic [1:0]  rq_size;
  logic        rq_cmd;
  logic [1:0]  rq_t_id;
  logic        mem_rdy;
  logic [15:0] mem_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_cmd, mem_bus_assert;
  logic        rs_valid;
  logic [15:0] rs_data;
  logic [1:0]  rs_t_id;
  logic        rs_cmd;

  int checks = 0;
  int errors = 0;

  lsu_queued #(.ADDR_W(16), .DATA_W(16), .DEPTH(2), .TID_W(2)) dut (
    .clk(clk), .a_rst(a_rst),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_addr(rq_addr), .rq_data(rq_data),
    .rq_size(rq_size), .rq_cmd(rq_cmd), .rq_t_id(rq_t_id),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_cmd(mem_cmd), .mem_bus_assert(mem_bus_assert),
    .rs_valid(rs_valid), .rs_data(rs_data), .rs_t_id(rs_t_id), .rs_cmd(rs_cmd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [15:0] a, input logic [15:0] d, input logic [1:0] sz,
                           input logic c, input logic [1:0] t);
    rq_addr = a; rq_data = d; rq_size = sz; rq_cmd = c; rq_t_id = t;
  endtask

  // Offer a request at a falling edge, return one cycle after it was accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] d, input logic [1:0] sz,
                      input logic c, input logic [1:0] t);
    int n;
    n = 0;
    drive_req(a, d, sz, c, t);
    rq_valid = 1'b1;
    while (!rq_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(rq_ready), 32'd1);
    @(negedge clk);
    rq_valid = 1'b0;
  endtask

  // Check the beat on the bus, stall for some cycles, then complete it.
  task automatic beat(input string tag, input logic [15:0] a, input logic [1:0] be,
                      input logic c, input logic [15:0] wd, input logic [15:0] rd,
                      input int waits);
    chk({tag, "_bus"}, 32'(mem_bus_assert), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_be"}, 32'(mem_be), 32'(be));
    chk({tag, "_cmd"}, 32'(mem_cmd), 32'(c));
    if (c) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(wd));
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, 32'({mem_addr, mem_be, mem_cmd}), 32'({a, be, c}));
    end
    mem_rdata = rd;
    mem_rdy   = 1'b1;
    @(negedge clk);
    mem_rdy   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic rsp(input string tag, input logic [1:0] t, input logic c, input logic [15:0] d);
    chk({tag, "_rsv"}, 32'(rs_valid), 32'd1);
    chk({tag, "_tid"}, 32'(rs_t_id), 32'(t));
    chk({tag, "_rcmd"}, 32'(rs_cmd), 32'(c));
    chk({tag, "_rdata"}, 32'(rs_data), 32'(d));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, 32'(rq_ready), 32'd1);
    chk({tag, "_bus"}, 32'(mem_bus_assert), 32'd0);
    chk({tag, "_rsv"}, 32'(rs_valid), 32'd0);
    chk({tag, "_mem"}, 32'({mem_be, mem_addr, mem_cmd}), 32'd0);
    chk({tag, "_wd"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rs"}, 32'({rs_data, rs_t_id, rs_cmd}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b0; rq_valid = 1'b0; mem_rdy = 1'b0; mem_rdata = '0;
    drive_req(16'h0, 16'h0, SIZE_1B, CMD_RD, 2'd0);
    #2;
    chk_idle("reset");
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    // Aligned halfword write: one beat, completion two cycles after enqueue.
    send(16'h0010, 16'hBEEF, SIZE_2B, CMD_WR, 2'd1);
    beat("wr", 16'h0010, 2'b11, CMD_WR, 16'hBEEF, 16'h0, 0);
    rsp("wr", 2'd1, CMD_WR, 16'h0);
    chk("wr_idle", 32'(mem_bus_assert), 32'd0);

    // Split halfword read across 0x0010/0x0012 with a wait state on beat 0.
    send(16'h0011, 16'h0, SIZE_2B, CMD_RD, 2'd2);
    beat("sp0", 16'h0010, 2'b10, CMD_RD, 16'h0, 16'h3412, 1);
    beat("sp1", 16'h0012, 2'b01, CMD_RD, 16'h0, 16'h7856, 0);
    rsp("sp", 2'd2, CMD_RD, 16'h5634);

    // Byte reads: upper lane and lower lane, zero-extended.
    send(16'h0013, 16'h0, SIZE_1B, CMD_RD, 2'd3);
    beat("by1", 16'h0012, 2'b10, CMD_RD, 16'h0, 16'hAB77, 0);
    rsp("by1", 2'd3, CMD_RD, 16'h00AB);
    chk("by1_single", 32'(mem_bus_assert), 32'd0);
    send(16'h0012, 16'h0, SIZE_1B, CMD_RD, 2'd0);
    beat("by0", 16'h0012, 2'b01, CMD_RD, 16'h0, 16'hABCD, 0);
    rsp("by0", 2'd0, CMD_RD, 16'h00CD);

    // 8-byte size clamps to the 2-byte bus word.
    send(16'h0014, 16'h0, SIZE_8B, CMD_RD, 2'd1);
    beat("clamp", 16'h0014, 2'b11, CMD_RD, 16'h0, 16'h9A8B, 0);
    rsp("clamp", 2'd1, CMD_RD, 16'h9A8B);
    chk("clamp_single", 32'(mem_bus_assert), 32'd0);

    // Split write: lane-shifted data on each beat.
    send(16'h0015, 16'hBEEF, SIZE_2B, CMD_WR, 2'd2);
    beat("sw0", 16'h0014, 2'b10, CMD_WR, 16'hEF00, 16'h0, 0);
    beat("sw1", 16'h0016, 2'b01, CMD_WR, 16'h00BE, 16'h0, 0);
    rsp("sw", 2'd2, CMD_WR, 16'h0);

    // Three requests against a stalled bus: queue fills, then drains in order.
    drive_req(16'h0020, 16'h0, SIZE_2B, CMD_RD, 2'd0);
    rq_valid = 1'b1;
    chk("q_rdy0", 32'(rq_ready), 32'd1);
    @(negedge clk);
    chk("q_rdy1", 32'(rq_ready), 32'd1);
    chk("q_bus", 32'(mem_bus_assert), 32'd1);
    drive_req(16'h0022, 16'h1111, SIZE_2B, CMD_WR, 2'd1);
    @(negedge clk);
    chk("q_full", 32'(rq_ready), 32'd0);
    drive_req(16'h0024, 16'h0, SIZE_2B, CMD_RD, 2'd2);
    @(negedge clk);
    chk("q_full2", 32'(rq_ready), 32'd0);
    chk("q_hold", 32'(mem_addr), 32'h0020);
    mem_rdy = 1'b1; mem_rdata = 16'h2222;
    @(negedge clk);
    mem_rdy = 1'b0; mem_rdata = '0;
    rsp("q0", 2'd0, CMD_RD, 16'h2222);
    chk("q_rdy_pop", 32'(rq_ready), 32'd1);
    chk("q_b2b", 32'({mem_bus_assert, mem_addr, mem_cmd, mem_be}), 32'({1'b1, 16'h0022, 1'b1, 2'b11}));
    chk("q_b2b_wd", 32'(mem_wdata), 32'h1111);
    @(negedge clk);
    rq_valid = 1'b0;
    chk("q_pulse", 32'(rs_valid), 32'd0);
    chk("q_full3", 32'(rq_ready), 32'd0);
    mem_rdy = 1'b1;
    @(negedge clk);
    rsp("q1", 2'd1, CMD_WR, 16'h0);
    chk("q_third", 32'({mem_addr, mem_cmd}), 32'({16'h0024, 1'b0}));
    mem_rdata = 16'h3333;
    @(negedge clk);
    mem_rdy = 1'b0; mem_rdata = '0;
    rsp("q2", 2'd2, CMD_RD, 16'h3333);
    chk("q_done", 32'(mem_bus_assert), 32'd0);

    // Split at top of memory wraps the second word address to 0.
    send(16'hFFFF, 16'h0, SIZE_2B, CMD_RD, 2'd3);
    beat("wr0", 16'hFFFE, 2'b10, CMD_RD, 16'h0, 16'hCD00, 0);
    beat("wr1", 16'h0000, 2'b01, CMD_RD, 16'h0, 16'h0055, 0);
    rsp("wrap", 2'd3, CMD_RD, 16'h55CD);

    // Reset during a stalled beat 1 drops the request without a completion.
    send(16'h0011, 16'h0, SIZE_2B, CMD_RD, 2'd1);
    beat("rb0", 16'h0010, 2'b10, CMD_RD, 16'h0, 16'h3412, 0);
    chk("rb1_addr", 32'(mem_addr), 32'h0012);
    @(negedge clk);
    a_rst = 1'b0;
    #1;
    chk_idle("rst_mid");
    @(negedge clk);
    mem_rdy = 1'b1;
    @(negedge clk);
    mem_rdy = 1'b0;
    a_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_quiet", 32'({rs_valid, mem_bus_assert}), 32'd0);
    end
    send(16'h0030, 16'h1234, SIZE_2B, CMD_WR, 2'd2);
    beat("after", 16'h0030, 2'b11, CMD_WR, 16'h1234, 16'h0, 0);
    rsp("after", 2'd2, CMD_WR, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_queued.md
# lsu_queued

Parametrised load/store unit that succeeds the single-slot 16-bit LSU. It accepts memory requests from the core pipeline into a DEPTH-entry request queue and issues them one at a time on a word-wide memory bus. Accesses that cross a bus-word boundary are split into two bus beats, and read results are merged before return. Every request returns a completion carrying its transaction id, so the core can keep several loads and stores in flight.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, bus and request data width; one of 16, 32, 64; NB = DATA_W/8 bytes
- DEPTH, 2, request queue entries; power of two, ≥ 2
- TID_W, 2, transaction id width
- clk  in  1  clock, rising edge
- a_rst  in  1  asynchronous active-low reset
- rq_valid  in  1  request offered
- rq_ready  out  1  queue can accept a request
- rq_addr  in  ADDR_W  byte address
- rq_data  in  DATA_W  write data, LSB-aligned
- rq_size  in  2  log2 of access bytes; 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = 8 bytes
- rq_cmd  in  1  1 = write, 0 = read
- rq_t_id  in  TID_W  transaction id
- mem_rdy  in  1  current beat completes this cycle
- mem_rdata  in  DATA_W  read data, sampled in the completing cycle
- mem_addr  out  ADDR_W  word-aligned address; low log2(NB) bits are 0
- mem_wdata  out  DATA_W  byte-lane-positioned write data
- mem_be  out  NB  byte-lane enables
- mem_cmd  out  1  1 = write
- mem_bus_assert  out  1  beat active
- rs_valid  out  1  one-cycle completion pulse
- rs_data  out  DATA_W  read result, LSB-aligned and zero-extended; 0 for writes
- rs_t_id  out  TID_W  id of the completed request
- rs_cmd  out  1  cmd of the completed request

## Operation
- Enqueue happens when rq_valid & rq_ready. rq_ready = ~full. There is no same-cycle enqueue/dequeue bypass when full.
- Access length: n = 1 << rq_size. A size larger than NB is clamped to NB. Offset o = addr mod NB.
- Issue FSM has three states: IDLE, BEAT0, BEAT1.
  - IDLE → BEAT0 when the queue is non-empty.
  - BEAT0 → BEAT1 on mem_rdy when o + n > NB.
  - On mem_rdy with no split pending, the FSM goes to BEAT0 if another entry is queued, otherwise to IDLE.
  - BEAT1 on mem_rdy goes to the same place.
- BEAT0 drives:
  - mem_addr = addr with its low bits cleared
  - mem_be = lanes o .. min(o+n, NB)-1
  - mem_wdata = data << 8·o
- BEAT1 drives:
  - mem_addr = that word address + NB, modulo 2^ADDR_W (it wraps at the top of memory)
  - mem_be = lanes 0 .. o+n-NB-1
  - mem_wdata = data >> 8·(NB-o)
- Read merge:
  - BEAT0 lanes o.. land in result bytes 0..
  - BEAT1 lanes 0.. land in result bytes NB-o..
  - Bytes at index ≥ n are forced to 0.
- An entry is dequeued in the cycle its final beat completes.
- mem_bus_assert = state ≠ IDLE.
- mem_addr, mem_wdata, mem_be and mem_cmd are held stable while mem_bus_assert is high and mem_rdy is low.

## Timing
- Reset values:
  - rq_ready 1; mem_bus_assert 0; rs_valid 0
  - mem_be 0; mem_addr, mem_wdata, mem_cmd, rs_data, rs_t_id and rs_cmd all 0
  - queue empty; FSM in IDLE
- Latency: a request enqueued into an empty queue in cycle T has mem_bus_assert high in T+1.
- Completion: if mem_rdy is high in cycle C (the final beat), rs_valid pulses in C+1. An aligned access with zero wait states therefore has rs_valid in T+2.
- Split access: BEAT1 is asserted in the cycle after BEAT0 completes, and mem_bus_assert stays high across the two beats.
- Back-to-back: the next entry's BEAT0 is driven in the cycle after the previous final beat, with no IDLE gap.
- Responses have no backpressure.
- Reset mid-beat drops all queued and in-flight requests. No rs_valid is produced for them.

## Structure
- Package lsu_pkg holds:
  - size encodings and cmd constants (CMD_RD, CMD_WR)
  - function be_mask(offset, len, nb), which returns the lane mask
- Sub-module lsu_req_fifo is a generic synchronous FIFO with DEPTH, width = ADDR_W+DATA_W+2+1+TID_W, asynchronous active-low reset and full/empty flags.
- The top level holds the issue FSM, lane shifters, merge register and response register.

## Test plan
- DATA_W=16, write 0xBEEF to 0x0010, size 1, t_id 1:
  - one beat, mem_be = 2'b11, mem_wdata = 0xBEEF
  - rs_valid in T+2 with rs_t_id 1
- Read of size 1 at 0x0011; memory word 0x0010 = 0x3412, word 0x0012 = 0x7856:
  - two beats, mem_be 2'b10 then 2'b01
  - rs_data = 0x5634
- Byte read at 0x0013 of lane 1 = 0xAB → rs_data = 0x00AB, single beat.
- Three requests with mem_rdy held low:
  - rq_ready drops after two are enqueued (DEPTH 2)
  - completions appear in order with the correct t_ids
- Read of size 1 at 0xFFFF → BEAT1 mem_addr = 0x0000.
- a_rst asserted during a stalled BEAT1:
  - all outputs return to reset values immediately
  - no rs_valid is produced
  - a new request after release completes normally
